// File: rtl/uart_tx_fsm_if.sv
// UART transmitter bus: byte/config from the data source, serial line and busy back.
interface uart_tx_fsm_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRE_WIDTH  = 5
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRE_WIDTH-1:0]  prescale;
    logic                  TX_OUT;
    logic                  busy;

    // Data source side
    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        input  TX_OUT, busy
    );

    // Transmitter side
    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, prescale,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Bit period is prescale clocks (0 treated as 1); all config latched on acceptance.
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRE_WIDTH  = 5
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_fsm_if.slave bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q,    state_d;
    logic [PRE_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic [PRE_WIDTH-1:0]  pre_q,      pre_d;
    logic                  tx_out_q,   tx_out_d;
    logic                  busy_q,     busy_d;

    logic                  bit_end_c;
    logic [CNT_W-1:0]      bit_nxt_c;
    logic [PRE_WIDTH-1:0]  edge_nxt_c;

    // Divider terminal count and counter increments
    assign bit_end_c  = (edge_cnt_q == (pre_q - PRE_WIDTH'(1)));
    assign bit_nxt_c  = bit_cnt_q + CNT_W'(1);
    assign edge_nxt_c = edge_cnt_q + PRE_WIDTH'(1);

    // Next-state, counters and registered line/busy values for the coming cycle
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        pre_d      = pre_q;
        tx_out_d   = tx_out_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                tx_out_d   = 1'b1;
                busy_d     = 1'b0;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (bus.DATA_VALID) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
                    pre_d     = (bus.prescale == '0) ? PRE_WIDTH'(1) : bus.prescale;
                    state_d   = START;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d    = DATA;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_out_d   = data_q[0];
                end else begin
                    edge_cnt_d = edge_nxt_c;
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_nxt_c;
                        tx_out_d  = data_q[bit_nxt_c];
                    end
                end else begin
                    edge_cnt_d = edge_nxt_c;
                end
            end
            PARITY: begin
                if (bit_end_c) begin
                    state_d    = STOP;
                    edge_cnt_d = '0;
                    tx_out_d   = 1'b1;
                end else begin
                    edge_cnt_d = edge_nxt_c;
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_out_d   = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    edge_cnt_d = edge_nxt_c;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_out_d   = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            pre_q      <= '0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            pre_q      <= pre_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: per-cycle line/busy checks against hand-built frames.
module tb_uart_tx_fsm;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_tx_fsm_if #(.DATA_WIDTH(8), .PRE_WIDTH(5)) bus ();

    uart_tx_fsm #(.DATA_WIDTH(8), .PRE_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Samples every cycle of a frame already accepted, then the idle cycle after it.
    // exp holds the frame bits with the start bit at index 0.
    task automatic monitor(input logic [15:0] exp, input int nbits, input int p,
                           input string tag, input bit drop_valid, input int inj);
        for (int i = 0; i < nbits * p; i++) begin
            @(negedge clk);
            if (i == 0 && drop_valid) bus.DATA_VALID = 1'b0;
            check($sformatf("%s_tx%0d", tag, i), bus.TX_OUT, exp[i / p]);
            check($sformatf("%s_busy%0d", tag, i), bus.busy, 1'b1);
            if (i == inj) begin
                bus.DATA_VALID = 1'b1;
                bus.P_DATA     = 8'hFF;
                bus.prescale   = 5'd7;
            end
        end
        @(negedge clk);
        check($sformatf("%s_idle_tx", tag), bus.TX_OUT, 1'b1);
        check($sformatf("%s_idle_busy", tag), bus.busy, 1'b0);
    endtask

    task automatic send(input logic [7:0] data, input logic par_en, input logic par_typ,
                        input logic [4:0] pre, input logic [15:0] exp, input int nbits,
                        input int p, input string tag, input int inj);
        @(negedge clk);
        bus.P_DATA     = data;
        bus.PAR_EN     = par_en;
        bus.PAR_TYP    = par_typ;
        bus.prescale   = pre;
        bus.DATA_VALID = 1'b1;
        monitor(exp, nbits, p, tag, 1'b1, inj);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.prescale   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", bus.TX_OUT, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx", bus.TX_OUT, 1'b1);
        check("idle_busy", bus.busy, 1'b0);

        // A5, even parity, P=4: 0,1,0,1,0,0,1,0,1,0,1 -> 44 busy cycles
        send(8'hA5, 1'b1, 1'b0, 5'd4, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 4, "t1", -1);

        // 01, no parity, P=4 -> 40 busy cycles
        send(8'h01, 1'b0, 1'b0, 5'd4, 16'({1'b1, 8'h01, 1'b0}), 10, 4, "t2", -1);

        // 01 parity: even -> 1, odd -> 0
        send(8'h01, 1'b1, 1'b0, 5'd2, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 2, "t3e", -1);
        send(8'h01, 1'b1, 1'b1, 5'd2, 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11, 2, "t3o", -1);

        // Request while busy (FF, prescale 7) must not disturb the 3C frame,
        // then starts one idle cycle after busy falls
        send(8'h3C, 1'b0, 1'b0, 5'd4, 16'({1'b1, 8'h3C, 1'b0}), 10, 4, "t4a", 6);
        monitor(16'({1'b1, 8'hFF, 1'b0}), 10, 7, "t4b", 1'b1, -1);

        // Reset in the middle of DATA (C3 bit2 = 0 on the line)
        @(negedge clk);
        bus.P_DATA     = 8'hC3;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.prescale   = 5'd4;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        repeat (13) @(negedge clk);
        check("t5_pre_tx", bus.TX_OUT, 1'b0);
        check("t5_pre_busy", bus.busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("t5_async_tx", bus.TX_OUT, 1'b1);
        check("t5_async_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("t5_rel_tx", bus.TX_OUT, 1'b1);
        check("t5_rel_busy", bus.busy, 1'b0);
        // 5A odd parity -> parity bit 1
        send(8'h5A, 1'b1, 1'b1, 5'd4, 16'({1'b1, 1'b1, 8'h5A, 1'b0}), 11, 4, "t5", -1);

        // prescale 0 behaves as 1: one bit per clock
        send(8'h96, 1'b0, 1'b0, 5'd0, 16'({1'b1, 8'h96, 1'b0}), 10, 1, "t6", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
